// File: rtl/eqz_pkg.sv
// eqz_pkg: definitions shared by the zero-detect flag bank and the
// controller that consumes its flags.
//   selw()      - width of a bank index for a given bank count (min 1)
//   cnt_sat()   - saturation value of a zero counter of a given width
//   DEF_CNTW    - default zero-counter width
//   DEF_CNT_SAT - saturation value of the default-width counter
//   flag_rec_t  - one bank's state record (eqz, valid, cnt) at default width
package eqz_pkg;

  function automatic int unsigned selw(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned cnt_sat(input int unsigned w);
    return (1 << w) - 1;
  endfunction

  localparam int unsigned DEF_CNTW = 4;
  localparam logic [DEF_CNTW-1:0] DEF_CNT_SAT = DEF_CNTW'(cnt_sat(DEF_CNTW));

  typedef struct packed {
    logic                eqz;
    logic                valid;
    logic [DEF_CNTW-1:0] cnt;
  } flag_rec_t;

endpackage

// File: rtl/eqz_flag_bank_if.sv
// eqz_flag_bank_if: load bus and status outputs of the flag bank.
//   ld/sel/z  - load strobe, target bank index, value under test
//   clr       - synchronous clear of all banks
//   eqz/neqz/valid/chg - per-bank status bits
//   zcnt      - per-bank zero counters, bank 0 in LSBs
// master: the controller side; slave: the flag bank.
interface eqz_flag_bank_if
  import eqz_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCH   = 2,
  parameter int unsigned CNTW  = 4
);
  localparam int unsigned SELW = selw(NCH);

  logic                ld;
  logic [SELW-1:0]     sel;
  logic [WIDTH-1:0]    z;
  logic                clr;
  logic [NCH-1:0]      eqz;
  logic [NCH-1:0]      neqz;
  logic [NCH-1:0]      valid;
  logic [NCH-1:0]      chg;
  logic [NCH*CNTW-1:0] zcnt;

  modport master (
    output ld, sel, z, clr,
    input  eqz, neqz, valid, chg, zcnt
  );

  modport slave (
    input  ld, sel, z, clr,
    output eqz, neqz, valid, chg, zcnt
  );
endinterface

// File: rtl/eqz_flag_cell.sv
// eqz_flag_cell: one zero-detect bank.
//   clk   - clock, rising edge
//   clr   - synchronous clear (reset and clr already merged), wins over ld
//   ld    - load qualifier for this bank
//   zero  - the tested value was zero
//   eqz   - last-tested value was zero (held once set when STICKY=1)
//   valid - bank loaded since last clear
//   chg   - one-cycle pulse when a load flips eqz on an already-valid bank
//   cnt   - saturating count of zero loads
module eqz_flag_cell #(
  parameter int unsigned CNTW   = 4,
  parameter bit          STICKY = 1'b0
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            ld,
  input  logic            zero,
  output logic            eqz,
  output logic            valid,
  output logic            chg,
  output logic [CNTW-1:0] cnt
);
  logic eqz_nxt;

  always_comb begin
    eqz_nxt = STICKY ? (eqz | zero) : zero;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      eqz   <= 1'b0;
      valid <= 1'b0;
      chg   <= 1'b0;
      cnt   <= '0;
    end else begin
      chg <= 1'b0;
      if (ld) begin
        eqz   <= eqz_nxt;
        valid <= 1'b1;
        // the first load after a clear establishes eqz rather than changing it
        chg   <= valid & (eqz_nxt != eqz);
        if (zero && (cnt != '1)) begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/eqz_flag_bank.sv
// eqz_flag_bank: NCH registered zero-detect banks for the datapath controller.
//   clk - clock, rising edge
//   rst - synchronous active-high reset (priority over clr and ld)
//   bus - slave side of eqz_flag_bank_if: ld/sel/z/clr in,
//         eqz/neqz/valid/chg/zcnt out; all outputs are registered or
//         derived from registers only.
// Interface parameters must match WIDTH/NCH/CNTW of this module.
module eqz_flag_bank
  import eqz_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NCH    = 2,
  parameter int unsigned CNTW   = 4,
  parameter bit          STICKY = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  eqz_flag_bank_if.slave  bus
);
  localparam int unsigned SELW = selw(NCH);

  logic           clr_all;
  logic           zero;
  logic [NCH-1:0] ld_q;
  logic [NCH-1:0] eqz_r;
  logic [NCH-1:0] valid_r;

  assign clr_all = rst | bus.clr;
  assign zero    = (bus.z == '0);

  for (genvar i = 0; i < NCH; i++) begin : g_bank
    // an out-of-range sel matches no bank, so the load is dropped
    assign ld_q[i] = bus.ld & ~clr_all & (bus.sel == SELW'(i));

    eqz_flag_cell #(
      .CNTW   (CNTW),
      .STICKY (STICKY)
    ) u_cell (
      .clk   (clk),
      .clr   (clr_all),
      .ld    (ld_q[i]),
      .zero  (zero),
      .eqz   (eqz_r[i]),
      .valid (valid_r[i]),
      .chg   (bus.chg[i]),
      .cnt   (bus.zcnt[i*CNTW +: CNTW])
    );
  end

  assign bus.eqz   = eqz_r;
  assign bus.valid = valid_r;
  assign bus.neqz  = valid_r & ~eqz_r;
endmodule
